apb_to_ahb_bridge: RTL
======================

APB_TO_AHB_BRIDGE -- requirements
Module: apb_to_ahb_bridge

Interface
REQ-001 Parameters: none; data and address are fixed at 32 bits; transfers are word-size only.
REQ-002 Ports, one per line (clock and reset first); the block SHALL provide exactly these:
- HCLK  in  1  clock for both the APB port and the AHB port
- HRESETN  in  1  reset, asynchronous, active-low
- PSEL  in  1  APB select
- PENABLE  in  1  APB access phase
- PWRITE  in  1  APB direction, 1 = write
- PADDR  in  32  APB address
- PWDATA  in  32  APB write data
- PRDATA  out  32  APB read data
- PREADY  out  1  APB transfer complete
- PSLVERR  out  1  APB error, valid with PREADY
- HADDR  out  32  AHB address
- HTRANS  out  2  AHB transfer type (IDLE = 00, NONSEQ = 10)
- HWRITE  out  1  AHB direction
- HSIZE  out  3  fixed 3'b010
- HBURST  out  3  fixed 3'b000 (SINGLE)
- HPROT  out  4  fixed 4'b0011
- HMASTLOCK  out  1  fixed 0
- HWDATA  out  32  AHB write data
- HRDATA  in  32  AHB read data
- HREADY  in  1  AHB ready
- HRESP  in  1  AHB response, 1 = ERROR

Function
REQ-003 FSM states: IDLE, ADDR, DATA, RESP.
REQ-004 IDLE: when PSEL=1 and PENABLE=0 at an HCLK edge, the block SHALL latch PADDR, PWRITE and PWDATA, clear the error flag and go to ADDR. In all other cases it SHALL stay in IDLE.
REQ-005 ADDR: the block SHALL drive HTRANS=NONSEQ, HADDR=latched address and HWRITE=latched direction. While HREADY=0 it SHALL hold these outputs. On HREADY=1 it SHALL go to DATA.
REQ-006 DATA: the block SHALL drive HTRANS=IDLE and HWDATA=latched write data (held stable until the transfer leaves DATA).
REQ-007 DATA: on HREADY=1, for a read, the block SHALL register HRDATA into PRDATA and go to RESP.
REQ-008 DATA: if HRESP=1 is sampled in any DATA cycle, the block SHALL set the error flag. The transfer SHALL still complete only on HREADY=1, covering the two-cycle ERROR response.
REQ-009 RESP: the block SHALL drive PREADY=1 and PSLVERR=error flag. At the edge with PSEL=1 and PENABLE=1, it SHALL go to IDLE.
REQ-010 RESP: if PSEL=0 (illegal abandon), the block SHALL go to IDLE silently.
REQ-011 PREADY SHALL be 0 in all states except RESP. PSLVERR SHALL be 0 whenever PREADY=0.
REQ-012 Latency with a zero-wait AHB slave: setup cycle, then three access cycles, with PREADY=1 in the third. Each AHB wait state adds exactly one APB access cycle.
REQ-013 The block SHALL issue at most one outstanding AHB transfer. HTRANS SHALL never be SEQ or BUSY.
REQ-014 PRDATA SHALL hold its last captured value until the next read completes. On writes, PRDATA SHALL be unchanged.
REQ-015 PSEL dropping during ADDR or DATA SHALL NOT abort the AHB transfer. The block SHALL complete the transfer and then behave as in REQ-010.
REQ-016 PSEL=1 with PENABLE=1 seen in IDLE without a prior setup phase SHALL be ignored; PREADY stays 0.

Reset
REQ-017 HRESETN low SHALL asynchronously force:
- state = IDLE
- HTRANS = 00, HADDR = 0, HWRITE = 0, HWDATA = 0
- PRDATA = 0, PREADY = 0, PSLVERR = 0
- error flag = 0
REQ-018 Reset asserted mid-transfer SHALL abandon the transfer. After release, the block SHALL accept only a fresh APB setup phase.
REQ-019 Constant outputs (HSIZE, HBURST, HPROT, HMASTLOCK) SHALL hold their fixed values during reset.

Structure
REQ-020 A shared package SHALL hold:
- the state encoding type
- the HTRANS encodings IDLE/NONSEQ
- the constants HSIZE_WORD, HBURST_SINGLE, HPROT_DATA_PRIV
REQ-021 The block SHALL be a single module with no sub-modules; all outputs SHALL be registered except the fixed constants.

Verification
REQ-022 Write 0xDEADBEEF to 0x10000004 with a zero-wait slave -> exactly one NONSEQ cycle with HWRITE=1; HWDATA=0xDEADBEEF in the next cycle; PREADY=1 in access cycle 3; PSLVERR=0.
REQ-023 Read 0x20000010, slave returns 0x12345678 with 2 wait states -> HADDR held through the waits; PRDATA=0x12345678 with PREADY=1 in access cycle 5.
REQ-024 Slave returns a two-cycle ERROR on a write -> PREADY=1 with PSLVERR=1 one cycle after the second ERROR cycle; the next transfer has PSLVERR=0.
REQ-025 HREADY=0 for 3 cycles during ADDR -> HTRANS=NONSEQ and HADDR stable for 4 cycles; exactly one transfer is issued.
REQ-026 HRESETN pulsed low in DATA -> all outputs at reset values immediately; a following read of 0x0 with data 0xA5A5A5A5 completes normally.
REQ-027 Back-to-back APB write then read with no idle cycle -> two NONSEQ transfers; HTRANS=IDLE between them; correct data each time.

Source files
------------

// File: rtl/apb_to_ahb_bridge_pkg.sv
// rtl/apb_to_ahb_bridge_pkg.sv - shared types and AHB encodings for the APB-to-AHB bridge
//
// Contents:
//   state_t          bridge FSM state encoding (IDLE, ADDR, DATA, RESP)
//   HTRANS_IDLE      AHB HTRANS encoding for an idle slot
//   HTRANS_NONSEQ    AHB HTRANS encoding for a single non-sequential transfer
//   HSIZE_WORD       32-bit transfer size
//   HBURST_SINGLE    single-beat burst
//   HPROT_DATA_PRIV  data access, privileged, non-bufferable, non-cacheable

package apb_to_ahb_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10,
    ST_RESP = 2'b11
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_WORD      = 3'b010;
  localparam logic [2:0] HBURST_SINGLE   = 3'b000;
  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

endpackage

// File: rtl/apb_to_ahb_bridge.sv
// rtl/apb_to_ahb_bridge.sv - APB slave to AHB master bridge, one word transfer at a time
//
// Ports:
//   HCLK, HRESETN                 shared clock, asynchronous active-low reset
//   PSEL, PENABLE, PWRITE         APB control from the requester
//   PADDR, PWDATA                 APB address and write data
//   PRDATA, PREADY, PSLVERR       APB response (PREADY high only in RESP)
//   HADDR, HTRANS, HWRITE         AHB address phase (NONSEQ only in ADDR)
//   HSIZE, HBURST, HPROT,
//   HMASTLOCK                     fixed AHB attributes (word, single, data/priv, unlocked)
//   HWDATA                        AHB write data, captured at APB setup
//   HRDATA, HREADY, HRESP         AHB response from the slave

module apb_to_ahb_bridge
  import apb_to_ahb_bridge_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESETN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  state_t      state_q, state_d;
  logic        err_q, err_d;
  logic [31:0] haddr_d;
  logic        hwrite_d;
  logic [31:0] hwdata_d;
  logic [31:0] prdata_d;
  logic [1:0]  htrans_d;
  logic        pready_d;
  logic        pslverr_d;

  // Attributes never change, so they are driven straight from constants and
  // remain valid while reset is asserted.
  assign HSIZE     = HSIZE_WORD;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_DATA_PRIV;
  assign HMASTLOCK = 1'b0;

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    haddr_d  = HADDR;
    hwrite_d = HWRITE;
    hwdata_d = HWDATA;
    prdata_d = PRDATA;

    case (state_q)
      ST_IDLE: begin
        // Only a genuine setup phase starts a transfer; an access phase seen
        // here (no prior setup, or left over after reset) is ignored.
        if (PSEL && !PENABLE) begin
          haddr_d  = PADDR;
          hwrite_d = PWRITE;
          hwdata_d = PWDATA;
          err_d    = 1'b0;
          state_d  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (HREADY) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        // ERROR is two cycles long (HREADY low then high); sticky flag catches
        // either cycle, completion still waits for HREADY.
        if (HRESP) begin
          err_d = 1'b1;
        end
        if (HREADY) begin
          if (!HWRITE) begin
            prdata_d = HRDATA;
          end
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        // Leave on the completing access edge, or silently if PSEL went away.
        if (!PSEL || PENABLE) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered, so they are decoded from the next state to line
    // up with the state they belong to.
    htrans_d  = (state_d == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    pready_d  = (state_d == ST_RESP);
    pslverr_d = (state_d == ST_RESP) && err_d;
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      err_q   <= 1'b0;
      HADDR   <= 32'h0;
      HTRANS  <= HTRANS_IDLE;
      HWRITE  <= 1'b0;
      HWDATA  <= 32'h0;
      PRDATA  <= 32'h0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
    end else begin
      err_q   <= err_d;
      HADDR   <= haddr_d;
      HTRANS  <= htrans_d;
      HWRITE  <= hwrite_d;
      HWDATA  <= hwdata_d;
      PRDATA  <= prdata_d;
      PREADY  <= pready_d;
      PSLVERR <= pslverr_d;
    end
  end

endmodule
